// File: rtl/mau_pkg.sv
// Shared definitions for the sub-word memory access unit: op codes, FSM
// state encoding, lane widths and request classification helpers.
package mau_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Every op below SW in the encoding is a load.
  function automatic logic is_load(input logic [2:0] op);
    return (op < OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
    logic bad;
    case (op)
      OP_LW, OP_SW:         bad = (lane != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = lane[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Lane logic for the access unit: merges store data into a read word and
// extracts/extends the addressed lane of a loaded word.
module mau_lane_merge
  import mau_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] load_word,
  input  logic [31:0] store_word,
  input  logic [31:0] store_data,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store path: replace only the addressed lane of the fetched word.
  always_comb begin
    merged = store_word;
    case (op)
      OP_SW:   merged = store_data;
      OP_SB:   merged[{lane, 3'b000} +: BYTE_W] = store_data[7:0];
      OP_SH:   merged[{lane[1], 4'b0000} +: HALF_W] = store_data[15:0];
      default: merged = store_word;
    endcase
  end

  // Load path: pick the lane, then sign- or zero-extend by op.
  always_comb begin
    byte_s = load_word[{lane, 3'b000} +: BYTE_W];
    half_s = load_word[{lane[1], 4'b0000} +: HALF_W];
    case (op)
      OP_LW:   loaded = load_word;
      OP_LB:   loaded = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  loaded = {24'd0, byte_s};
      OP_LH:   loaded = {{16{half_s[15]}}, half_s};
      OP_LHU:  loaded = {16'd0, half_s};
      default: loaded = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sub-word load/store front end for a word-only data memory; byte/halfword
// stores run as read-modify-write. MAU_ALIGN_CHECK_EN enables misalignment errors.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  if (WORD_ADDR_BITS < 1 || WORD_ADDR_BITS > 30) begin : g_bad_word_addr_bits
    $error("mem_access_unit: WORD_ADDR_BITS out of range");
  end

  state_t      state_r;
  logic [2:0]  op_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] pc_r;
  logic [31:0] word_r;
  logic [31:0] rdata_r;
`ifdef MAU_ALIGN_CHECK_EN
  logic        err_r;
`endif
  logic [31:0] merged_s;
  logic [31:0] loaded_s;
  logic [31:0] word_addr_s;

  assign word_addr_s = {addr_r[31:2], 2'b00};

  mau_lane_merge u_lane_merge (
    .op         (op_r),
    .lane       (addr_r[1:0]),
    .load_word  (dm_rdata),
    .store_word (word_r),
    .store_data (wdata_r),
    .merged     (merged_s),
    .loaded     (loaded_s)
  );

  // Request FSM and its latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      op_r    <= 3'd0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      pc_r    <= 32'd0;
      word_r  <= 32'd0;
      rdata_r <= 32'd0;
`ifdef MAU_ALIGN_CHECK_EN
      err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            op_r    <= req_op;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            pc_r    <= req_pc;
`ifdef MAU_ALIGN_CHECK_EN
            err_r   <= 1'b0;
            if (is_misaligned(req_op, req_addr[1:0])) begin
              err_r   <= 1'b1;
              rdata_r <= 32'd0;
              state_r <= S_DONE;
            end else if (req_op == OP_SW) begin
              state_r <= S_WRITE;
            end else begin
              state_r <= S_READ;
            end
`else
            if (req_op == OP_SW) begin
              state_r <= S_WRITE;
            end else begin
              state_r <= S_READ;
            end
`endif
          end
        end
        S_READ: begin
          if (is_load(op_r)) begin
            rdata_r <= loaded_s;
            state_r <= S_DONE;
          end else begin
            word_r  <= dm_rdata;
            state_r <= S_WRITE;
          end
        end
        S_WRITE: begin
          rdata_r <= 32'd0;
          state_r <= S_DONE;
        end
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Output decode; the write enable is gated by reset so an aborted write never lands.
  always_comb begin
    req_ready  = (state_r == S_IDLE);
    resp_valid = (state_r == S_DONE);
    resp_rdata = rdata_r;
    dm_pc      = pc_r;
    dm_addr    = 32'd0;
    dm_wdata   = 32'd0;
    dm_we      = 1'b0;
    case (state_r)
      S_READ: dm_addr = word_addr_s;
      S_WRITE: begin
        dm_addr  = word_addr_s;
        dm_wdata = merged_s;
        dm_we    = !reset;
      end
      default: dm_addr = 32'd0;
    endcase
  end

`ifdef MAU_ALIGN_CHECK_EN
  assign resp_err = err_r;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sub-word load/store front end sitting directly upstream of the word-only data memory (1024 × 32, full-word writes, combinational read). It accepts one memory request at a time from the CPU MEM stage and drives the memory's address, write data, write enable and PC inputs. Byte and halfword stores become a read-modify-write sequence. Load data returns aligned and sign- or zero-extended.

## Interface
- WORD_ADDR_BITS, 10, word-index width of the data memory (address bits [WORD_ADDR_BITS+1:2] select the word)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  operation code (see Operation)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_pc  in  32  PC of the requesting instruction
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result (0 for stores)
- resp_err  out  1  misaligned access flag (valid with resp_valid)
- dm_addr  out  32  word-aligned address to memory
- dm_wdata  out  32  full word to write
- dm_we  out  1  memory write enable
- dm_pc  out  32  PC forwarded to memory for its write trace
- dm_rdata  in  32  memory combinational read data

## Operation
- Op codes: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH.
- Little-endian lanes:
  - byte lane b = addr[1:0] occupies bits [8b+7:8b]
  - halfword lane h = addr[1] occupies bits [16h+15:16h]
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, latch op, addr, wdata and pc. Loads, SB and SH go to READ. SW goes to WRITE.
  - READ: dm_addr = {addr_q[31:2],2'b00}. Loads capture the extended lane of dm_rdata into rdata_q and go to DONE. SB/SH capture dm_rdata into word_q and go to WRITE.
  - WRITE: dm_we=1 and dm_addr as in READ, then go to DONE. dm_wdata is wdata_q for SW, or word_q with the selected lane replaced by wdata_q[7:0] (SB) or wdata_q[15:0] (SH).
  - DONE: resp_valid=1, req_ready=0, then go to IDLE.
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- resp_rdata holds rdata_q until the next load completes. A store completion loads 0 into rdata_q.
- dm_pc = pc_q in all states. In IDLE, dm_addr=0, dm_wdata=0, dm_we=0.
- dm_we = (state==WRITE) && !reset. An aborted write never reaches memory.
- Undefined req_op values cannot occur, because the 3-bit encoding is complete.

## Timing
- Accept at edge T (req_valid && req_ready).
- Latency from accept to resp_valid:
  - LW/LB/LBU/LH/LHU: high in cycle T+2 (READ at T+1).
  - SW: write at T+1, resp_valid at T+2.
  - SB/SH: READ at T+1, WRITE at T+2, resp_valid at T+3.
- req_ready is low from T+1 until the cycle after DONE. A request held during DONE is accepted on the following cycle. No back-to-back overlap occurs.
- The memory commits a write at the edge ending the WRITE cycle. A read in the cycle immediately after sees the new data.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_pc=0, all latches 0.
- Reset mid-operation in any state: return to IDLE next cycle, with no response pulse and no write.

## Configuration
- MAU_ALIGN_CHECK_EN defined:
  - A request is misaligned if LW/SW has addr[1:0]≠0, or LH/LHU/SH has addr[0]=1.
  - A misaligned request goes IDLE→DONE directly, with no DM read or write.
  - resp_err=1 and resp_rdata=0 for that response.
- Macro undefined:
  - resp_err is tied 0.
  - Word ops ignore addr[1:0]. Halfword ops ignore addr[0].
  - Misaligned requests proceed normally at the truncated address.

## Structure
- Shared package mau_pkg holds:
  - op-code localparams (OP_LW…OP_SH)
  - state encoding (S_IDLE, S_READ, S_WRITE, S_DONE)
  - helper constants for lane width
- One sub-module, mau_lane_merge: combinational merge (store) and extract/extend (load) logic, instanced once. The FSM and latches stay in mem_access_unit.

## Test plan
- Word round trip: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → dm_we one cycle with dm_wdata 0xDEADBEEF; LW resp_rdata 0xDEADBEEF at T+2.
- Byte store merge: memory word 0x11223344 at 0x20, SB addr 0x22 data 0xAA → dm_wdata 0x11AA3344, resp_valid at T+3.
- Byte load extension: LB 0x22 → 0xFFFFFFAA; LBU 0x22 → 0x000000AA.
- Halfword: SH 0x32 data 0x8001 over 0x00000000 → word 0x80010000; LH 0x32 → 0xFFFF8001; LHU 0x32 → 0x00008001.
- Reset mid read-modify-write: SB accepted, reset asserted in WRITE cycle → dm_we stays 0, memory unchanged, resp_valid never pulses, req_ready=1 next cycle.
- With MAU_ALIGN_CHECK_EN: LW 0x13 → no DM access, resp_valid at T+1 with resp_err=1 and resp_rdata 0. Without the macro, the same request returns the word at 0x10.
